// File: rtl/seq_divider_8by4_if.sv
// rtl/seq_divider_8by4_if.sv - operand/result bundle for the 8-by-4 sequential divider
interface seq_divider_8by4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_8by4.sv
// rtl/seq_divider_8by4.sv - restoring divider, 8-bit dividend by 4-bit divisor, one quotient bit per cycle
module seq_divider_8by4 (
  input  logic              clk,
  input  logic              rst,
  seq_divider_8by4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] dvd_r;
  logic [3:0] dsr_r;
  logic [4:0] pr;
  logic [7:0] q_work;
  logic [3:0] cnt;
  logic       busy_r;
  logic       done_r;
  logic       dz_r;
  logic [7:0] quo_r;
  logic [3:0] rem_r;

  logic [2:0] bit_idx;
  logic [4:0] pr_shift;
  logic [4:0] pr_next;
  logic       q_bit;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    bit_idx  = 3'd7 - cnt[2:0];
    pr_shift = {pr[3:0], dvd_r[bit_idx]};
    q_bit    = (pr_shift >= {1'b0, dsr_r});
    pr_next  = q_bit ? (pr_shift - {1'b0, dsr_r}) : pr_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dvd_r  <= 8'd0;
      dsr_r  <= 4'd0;
      pr     <= 5'd0;
      q_work <= 8'd0;
      cnt    <= 4'd0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      quo_r  <= 8'd0;
      rem_r  <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start) begin
            dvd_r  <= bus.dividend;
            dsr_r  <= bus.divisor;
            pr     <= 5'd0;
            q_work <= 8'd0;
            cnt    <= 4'd0;
            if (bus.divisor == 4'd0) begin
              state  <= DONE;
              done_r <= 1'b1;
              quo_r  <= 8'hFF;
              rem_r  <= bus.dividend[3:0];
              dz_r   <= 1'b1;
            end else begin
              state <= CALC;
              dz_r  <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          // Eight iteration edges raise busy; the ninth publishes the result.
          if (cnt == 4'd8) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            quo_r  <= q_work;
            rem_r  <= pr[3:0];
          end else begin
            pr     <= pr_next;
            q_work <= {q_work[6:0], q_bit};
            cnt    <= cnt + 4'd1;
            busy_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
endmodule

// File: tb/tb_seq_divider_8by4.sv
// tb/tb_seq_divider_8by4.sv - self-checking bench for seq_divider_8by4
module tb_seq_divider_8by4;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  seq_divider_8by4_if bus ();

  seq_divider_8by4 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input logic [7:0] a, input logic [3:0] b,
                       output logic [7:0] q, output logic [3:0] r, output logic dz);
    if (b == 4'd0) begin
      q  = 8'hFF;
      r  = a[3:0];
      dz = 1'b1;
    end else begin
      q  = 8'(a / b);
      r  = 4'(a % b);
      dz = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one start and watches up to 20 edges; lat = edges after the capture edge until done.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       output int lat, output int busy_cnt, output logic overlap,
                       output logic [7:0] q, output logic [3:0] r, output logic dz);
    lat      = -1;
    busy_cnt = 0;
    overlap  = 1'b0;
    q        = 8'hxx;
    r        = 4'hx;
    dz       = 1'bx;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) tick();
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.done) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        dz  = bus.div_by_zero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    rst          = 1'b1;
    bus.start    = 1'b1;
    bus.dividend = 8'd143;
    bus.divisor  = 4'd11;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.busy || bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL start_during_reset: got %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic ov, dz;
    logic [7:0] q;
    logic [3:0] r;
    do_op(8'd143, 4'd11, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 9 || bc !== 8 || ov !== 1'b0) begin
      errors++;
      $display("FAIL basic_timing: got lat=%0d busy=%0d overlap=%b, want 9 8 0", lat, bc, ov);
    end
    checks++;
    if (q !== 8'd13 || r !== 4'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d dz=%b, want 13 0 0", q, r, dz);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: got done=%b, want 0", bus.done);
    end
    tick();
    tick();
    checks++;
    if (bus.quotient !== 8'd13 || bus.remainder !== 4'd0) begin
      errors++;
      $display("FAIL result_hold: got q=%0d r=%0d, want 13 0", bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic ov, dz;
    logic [7:0] q;
    logic [3:0] r;
    do_op(8'd200, 4'd15, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 9 || q !== 8'd13 || r !== 4'd5 || dz !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d dz=%b, want 9 13 5 0", lat, q, r, dz);
    end
    do_op(8'd255, 4'd1, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 9 || bc !== 8 || ov !== 1'b0 || q !== 8'd255 || r !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d busy=%0d ov=%b q=%0d r=%0d, want 9 8 0 255 0",
               lat, bc, ov, q, r);
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bc;
    logic ov, dz;
    logic [7:0] q;
    logic [3:0] r;
    do_op(8'h5A, 4'd0, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 0 || bc !== 0) begin
      errors++;
      $display("FAIL dbz_timing: got lat=%0d busy=%0d, want 0 0", lat, bc);
    end
    checks++;
    if (q !== 8'hFF || r !== 4'hA || dz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got q=%h r=%h dz=%b, want ff a 1", q, r, dz);
    end
    tick();
    do_op(8'd9, 4'd2, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 9 || q !== 8'd4 || r !== 4'd1 || dz !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear: got lat=%0d q=%0d r=%0d dz=%b, want 9 4 1 0", lat, q, r, dz);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    logic leak;
    logic [7:0] prev_q, q;
    logic [3:0] r;
    prev_q = bus.quotient;
    leak   = 1'b0;
    lat    = -1;
    q      = 8'hxx;
    r      = 4'hx;
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 4'd7;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.start = 1'b0;
      if (bus.busy && bus.quotient !== prev_q) leak = 1'b1;
      if (bus.done) begin
        lat = k;
        q   = bus.quotient;
        r   = bus.remainder;
        break;
      end
      if (k == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 4'd3;
      end
    end
    checks++;
    if (lat !== 9 || q !== 8'd14 || r !== 4'd2) begin
      errors++;
      $display("FAIL start_in_calc: got lat=%0d q=%0d r=%0d, want 9 14 2", lat, q, r);
    end
    checks++;
    if (leak !== 1'b0) begin
      errors++;
      $display("FAIL intermediate_visible: got leak=%b, want 0", leak);
    end
  endtask

  task automatic test_reset_abort();
    int seen, lat, bc;
    logic ov, dz;
    logic [7:0] q;
    logic [3:0] r;
    tick();
    bus.start    = 1'b1;
    bus.dividend = 8'd255;
    bus.divisor  = 4'd2;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== 15'd0) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
    end
    rst  = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses, want 0", seen);
    end
    do_op(8'd144, 4'd12, lat, bc, ov, q, r, dz);
    checks++;
    if (lat !== 9 || q !== 8'd12 || r !== 4'd0 || dz !== 1'b0) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d q=%0d r=%0d dz=%b, want 9 12 0 0", lat, q, r, dz);
    end
  endtask

  task automatic test_exhaustive_inverse();
    int lat, bc;
    logic ov, dz;
    logic [7:0] q, a;
    logic [3:0] r;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 1; ib < 16; ib++) begin
        a = 8'(ia * ib);
        do_op(a, 4'(ib), lat, bc, ov, q, r, dz);
        checks++;
        if (lat !== 9 || q !== 8'(ia) || r !== 4'd0) begin
          errors++;
          $display("FAIL inverse %0d/%0d: got lat=%0d q=%0d r=%0d, want 9 %0d 0",
                   a, ib, lat, q, r, ia);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, gap;
    logic ov, dz, edz;
    logic [7:0] q, a, eq;
    logic [3:0] r, b, er;
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      model(a, b, eq, er, edz);
      do_op(a, b, lat, bc, ov, q, r, dz);
      checks++;
      if (lat !== ((b == 4'd0) ? 0 : 9) || bc !== ((b == 4'd0) ? 0 : 8) || ov !== 1'b0) begin
        errors++;
        $display("FAIL rand_timing %0d/%0d: got lat=%0d busy=%0d ov=%b", a, b, lat, bc, ov);
      end
      checks++;
      if (q !== eq || r !== er || dz !== edz) begin
        errors++;
        $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d dz=%b, want %0d %0d %b",
                 a, b, q, r, dz, eq, er, edz);
      end
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      if (gap > 0) begin
        checks++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
          errors++;
          $display("FAIL rand_hold: got q=%0d r=%0d dz=%b, want %0d %0d %b",
                   bus.quotient, bus.remainder, bus.div_by_zero, eq, er, edz);
        end
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_ignored();
    test_reset_abort();
    test_exhaustive_inverse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
